// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants for the RISC-V datapath.
package riscv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect and decode handshake.
interface riscv_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );

endinterface

// File: rtl/riscv_fetch_checker.sv
// Invariant checks for the fetch stage: buffer overflow and FSM/discard consistency.
module riscv_fetch_checker (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full,
    input logic in_flush,
    input logic discard_nz
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    a_flush_state: assert property (@(posedge clk) disable iff (rst) in_flush == discard_nz);

endmodule

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO with push/pop/flush; DEPTH must be a power of two.
module riscv_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push into a full buffer is accepted only when the head leaves the same cycle
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == '0);
    assign count   = count_r;

endmodule

// File: rtl/riscv_fetch_stage.sv
// RISC-V instruction fetch front end: PC, imem credits, fetch buffer and redirect flush.
// Optional RISCV_FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module riscv_fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic           clk,
    input logic           rst,
    riscv_fetch_if.master bus
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_discarded
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      pc_r;
    logic [31:0]      rsp_pc_r;
    logic [OUT_W-1:0] outstanding_r;
    logic [OUT_W-1:0] outstanding_next_s;
    logic [OUT_W-1:0] discard_r;
    logic [OUT_W-1:0] discard_next_s;
    fetch_state_e     state_r;
    fetch_state_e     state_next_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_entry_s;

    // Issue credit: memory slots still free and buffer room for every word in flight
    always_comb begin
        if (!rst && !bus.redirect_valid
            && (32'(outstanding_r) < 32'(MAX_OUTSTANDING))
            && ((32'(outstanding_r) + 32'(fifo_count_s)) < 32'(FIFO_DEPTH))) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        req_fire_s         = req_valid_s && bus.imem_req_ready;
        pop_s              = !fifo_empty_s && bus.id_ready && !bus.redirect_valid;
        outstanding_next_s = outstanding_r + OUT_W'(req_fire_s) - OUT_W'(bus.imem_rsp_valid);
    end

    // Next-state and response routing: stale words are counted down in FLUSH
    always_comb begin
        push_s         = 1'b0;
        drop_s         = 1'b0;
        discard_next_s = discard_r;
        state_next_s   = FETCH_RUN;
        if (bus.redirect_valid) begin
            drop_s         = bus.imem_rsp_valid;
            discard_next_s = outstanding_next_s;
        end else begin
            case (state_r)
                FETCH_RUN: begin
                    push_s = bus.imem_rsp_valid;
                end
                FETCH_FLUSH: begin
                    drop_s = bus.imem_rsp_valid;
                    if (bus.imem_rsp_valid) begin
                        discard_next_s = discard_r - OUT_W'(1);
                    end else begin
                        discard_next_s = discard_r;
                    end
                end
                default: begin
                    drop_s         = bus.imem_rsp_valid;
                    discard_next_s = '0;
                end
            endcase
        end
        if (discard_next_s != '0) begin
            state_next_s = FETCH_FLUSH;
        end else begin
            state_next_s = FETCH_RUN;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC, response PC and credit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
            if (bus.redirect_valid) begin
                pc_r     <= word_align(bus.redirect_pc);
                rsp_pc_r <= word_align(bus.redirect_pc);
            end else begin
                if (req_fire_s) begin
                    pc_r <= pc_r + 32'd4;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                end
            end
        end
    end

    assign push_entry_s = '{instr: bus.imem_rsp_data, pc: rsp_pc_r};

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (bus.redirect_valid),
        .wr_data (push_entry_s),
        .rd_data (head_entry_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    riscv_fetch_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .in_flush   (state_r == FETCH_FLUSH),
        .discard_nz (discard_r != '0)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.id_valid       = !fifo_empty_s;
    assign bus.id_instr       = fifo_empty_s ? NOP_INSTR : head_entry_s.instr;
    assign bus.id_pc          = head_entry_s.pc;
    assign bus.id_pc_plus4    = head_entry_s.pc + 32'd4;

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_discarded_r;

    // Pops to decode, plus flushed entries and dropped responses
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r   <= 32'd0;
            perf_discarded_r <= 32'd0;
        end else begin
            perf_fetched_r   <= perf_fetched_r + 32'(pop_s);
            perf_discarded_r <= perf_discarded_r + 32'(drop_s)
                                + (bus.redirect_valid ? 32'(fifo_count_s) : 32'd0);
        end
    end

    assign perf_fetched   = perf_fetched_r;
    assign perf_discarded = perf_discarded_r;
`endif

endmodule
